// File: rtl/fifo_tb_pkg.sv
// Shared types and helpers for the async-FIFO read-side sequence checker.
// Holds the checker state encoding, default widths and the saturating-increment helper.
package fifo_tb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int CNT_WIDTH_DEF  = 32;

    // Works on counters up to 64 bits wide; callers zero-extend and truncate back.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? max_v : v + 64'd1;
    endfunction

endpackage

// File: rtl/fifo_rd_valid_pipe.sv
// Tracks accepted FIFO reads until their data appears, RD_LATENCY cycles later.
// drain_done looks ahead one cycle so DRAIN can exit on the edge of the last strobe.
module fifo_rd_valid_pipe #(
    parameter int RD_LATENCY = 1
) (
    input  logic rd_clk,
    input  logic rst_n,
    input  logic rd_accept,
    output logic data_valid,
    output logic drain_done
);

    logic [RD_LATENCY-1:0] pipe_q;
    logic [RD_LATENCY-1:0] pipe_d;

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = rd_accept;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign data_valid = pipe_q[RD_LATENCY-1];
    assign drain_done = (pipe_d == '0);

endmodule

// File: rtl/fifo_seq_checker.sv
// Read-side consumer for the async FIFO test environment: drains the FIFO and
// checks that received words form a +1 sequence, reporting counts and the first mismatch.
module fifo_seq_checker
    import fifo_tb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int RD_LATENCY = 1
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic                  err_flag,
    output logic [DATA_WIDTH-1:0] first_err_exp,
    output logic [DATA_WIDTH-1:0] first_err_got,
    output logic [DATA_WIDTH-1:0] last_data
);

    state_e                state_q, state_d;
    logic                  busy_q, busy_d;
    logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic                  err_flag_q, err_flag_d;
    logic [DATA_WIDTH-1:0] first_err_exp_q, first_err_exp_d;
    logic [DATA_WIDTH-1:0] first_err_got_q, first_err_got_d;
    logic [DATA_WIDTH-1:0] last_data_q, last_data_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic                  sync_q, sync_d;

    logic rd_accept;
    logic data_valid;
    logic drain_done;

    assign rd_accept  = (state_q == RUN) && !fifo_empty;
    assign fifo_rd_en = rd_accept;

    fifo_rd_valid_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_valid_pipe (
        .rd_clk     (rd_clk),
        .rst_n      (rst_n),
        .rd_accept  (rd_accept),
        .data_valid (data_valid),
        .drain_done (drain_done)
    );

    always_comb begin
        state_d         = state_q;
        word_cnt_d      = word_cnt_q;
        err_cnt_d       = err_cnt_q;
        err_flag_d      = err_flag_q;
        first_err_exp_d = first_err_exp_q;
        first_err_got_d = first_err_got_q;
        last_data_d     = last_data_q;
        exp_d           = exp_q;
        sync_d          = sync_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d         = RUN;
                    word_cnt_d      = '0;
                    err_cnt_d       = '0;
                    err_flag_d      = 1'b0;
                    first_err_exp_d = '0;
                    first_err_got_d = '0;
                    last_data_d     = '0;
                    sync_d          = 1'b0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The checker resyncs on every word, so one dropped word costs exactly one error.
        if (data_valid) begin
            word_cnt_d  = CNT_WIDTH'(sat_inc(64'(word_cnt_q), CNT_WIDTH));
            last_data_d = fifo_data;
            if (!sync_q) begin
                sync_d = 1'b1;
            end else if (fifo_data != exp_q) begin
                err_cnt_d = CNT_WIDTH'(sat_inc(64'(err_cnt_q), CNT_WIDTH));
                if (!err_flag_q) begin
                    err_flag_d      = 1'b1;
                    first_err_exp_d = exp_q;
                    first_err_got_d = fifo_data;
                end
            end
            exp_d = fifo_data + DATA_WIDTH'(1);
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            busy_q          <= 1'b0;
            word_cnt_q      <= '0;
            err_cnt_q       <= '0;
            err_flag_q      <= 1'b0;
            first_err_exp_q <= '0;
            first_err_got_q <= '0;
            last_data_q     <= '0;
            exp_q           <= '0;
            sync_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            busy_q          <= busy_d;
            word_cnt_q      <= word_cnt_d;
            err_cnt_q       <= err_cnt_d;
            err_flag_q      <= err_flag_d;
            first_err_exp_q <= first_err_exp_d;
            first_err_got_q <= first_err_got_d;
            last_data_q     <= last_data_d;
            exp_q           <= exp_d;
            sync_q          <= sync_d;
        end
    end

    assign busy          = busy_q;
    assign word_cnt      = word_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign err_flag      = err_flag_q;
    assign first_err_exp = first_err_exp_q;
    assign first_err_got = first_err_got_q;
    assign last_data     = last_data_q;

endmodule

// File: tb/tb_fifo_seq_checker.sv
// Directed bench for fifo_seq_checker: one instance at read latency 1, one at latency 2,
// each fed by a simple FIFO model preloaded with hand-chosen sequences.
module tb_fifo_seq_checker;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Instance A: RD_LATENCY = 1
    logic        a_start = 1'b0, a_stop = 1'b0;
    logic        a_empty, a_rd_en, a_busy, a_err_flag;
    logic [15:0] a_data = '0, a_fexp, a_fgot, a_last;
    logic [31:0] a_wc, a_ec;
    logic [15:0] mem_a [0:255];
    logic [31:0] rdp_a = '0, fill_a = '0;
    int          viol_a = 0;

    assign a_empty = (rdp_a == fill_a);

    always @(posedge clk) begin
        if (a_rd_en) begin
            a_data <= mem_a[rdp_a[7:0]];
            rdp_a  <= rdp_a + 1;
        end
    end

    always @(negedge clk) begin
        if (a_rd_en && a_empty) viol_a <= viol_a + 1;
    end

    fifo_seq_checker #(.DATA_WIDTH(16), .CNT_WIDTH(32), .RD_LATENCY(1)) dut_a (
        .rd_clk        (clk),
        .rst_n         (rst_n),
        .start         (a_start),
        .stop          (a_stop),
        .fifo_empty    (a_empty),
        .fifo_data     (a_data),
        .fifo_rd_en    (a_rd_en),
        .busy          (a_busy),
        .word_cnt      (a_wc),
        .err_cnt       (a_ec),
        .err_flag      (a_err_flag),
        .first_err_exp (a_fexp),
        .first_err_got (a_fgot),
        .last_data     (a_last)
    );

    // Instance B: RD_LATENCY = 2
    logic        b_start = 1'b0, b_stop = 1'b0;
    logic        b_empty, b_rd_en, b_busy, b_err_flag;
    logic [15:0] b_d1 = '0, b_data = '0, b_fexp, b_fgot, b_last;
    logic [31:0] b_wc, b_ec;
    logic [15:0] mem_b [0:255];
    logic [31:0] rdp_b = '0, fill_b = '0;

    assign b_empty = (rdp_b == fill_b);

    always @(posedge clk) begin
        if (b_rd_en) begin
            b_d1  <= mem_b[rdp_b[7:0]];
            rdp_b <= rdp_b + 1;
        end
        b_data <= b_d1;
    end

    fifo_seq_checker #(.DATA_WIDTH(16), .CNT_WIDTH(32), .RD_LATENCY(2)) dut_b (
        .rd_clk        (clk),
        .rst_n         (rst_n),
        .start         (b_start),
        .stop          (b_stop),
        .fifo_empty    (b_empty),
        .fifo_data     (b_data),
        .fifo_rd_en    (b_rd_en),
        .busy          (b_busy),
        .word_cnt      (b_wc),
        .err_cnt       (b_ec),
        .err_flag      (b_err_flag),
        .first_err_exp (b_fexp),
        .first_err_got (b_fgot),
        .last_data     (b_last)
    );

    // Discards any unread words, then makes the queue visible at once.
    task automatic load_a(input logic [15:0] v[$]);
        logic [31:0] base;
        base = rdp_a;
        foreach (v[i]) mem_a[8'(base + 32'(i))] = v[i];
        fill_a = base + 32'(v.size());
    endtask

    task automatic seq_q(input logic [15:0] first, input int n, output logic [15:0] q[$]);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(first + 16'(i));
    endtask

    task automatic pulse_a_start;
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
    endtask

    task automatic wait_a_wc(input string tag, input logic [31:0] target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (a_wc == target) break;
        end
        chk(tag, a_wc, target);
    endtask

    task automatic stop_a(input string tag);
        @(posedge clk); #1 a_stop = 1'b1;
        @(posedge clk); #1 a_stop = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!a_busy) break;
        end
        chk(tag, a_busy, 0);
    endtask

    logic [15:0] q[$];
    logic [31:0] base4;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_wc", a_wc, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_rden", a_rd_en, 0);
        chk("rst_errflag", a_err_flag, 0);
        rst_n = 1'b1;

        // 0..99 clean run
        seq_q(16'd0, 100, q);
        load_a(q);
        pulse_a_start();
        wait_a_wc("t1_wc", 100, 300);
        chk("t1_rden_empty", a_rd_en, 0);
        chk("t1_busy_run", a_busy, 1);
        pulse_a_start();
        @(negedge clk);
        chk("t1_start_ignored", a_wc, 100);
        stop_a("t1_idle");
        chk("t1_ec", a_ec, 0);
        chk("t1_flag", a_err_flag, 0);
        chk("t1_last", a_last, 16'd99);
        repeat (5) @(negedge clk);
        chk("t1_idle_stable", a_wc, 100);

        // Dropped word 5
        q = {16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd6, 16'd7, 16'd8, 16'd9};
        load_a(q);
        pulse_a_start();
        wait_a_wc("t2_wc", 9, 50);
        stop_a("t2_idle");
        chk("t2_ec", a_ec, 1);
        chk("t2_flag", a_err_flag, 1);
        chk("t2_fexp", a_fexp, 16'd5);
        chk("t2_fgot", a_fgot, 16'd6);

        // Wrap through 0xFFFF, with start and stop in the same IDLE cycle
        q = {16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        load_a(q);
        @(posedge clk); #1 a_start = 1'b1; a_stop = 1'b1;
        @(posedge clk); #1 a_start = 1'b0; a_stop = 1'b0;
        wait_a_wc("t3_wc", 4, 50);
        chk("t3_busy_start_wins", a_busy, 1);
        chk("t3_cleared_flag", a_err_flag, 0);
        stop_a("t3_idle");
        chk("t3_ec", a_ec, 0);
        chk("t3_last", a_last, 16'h0001);

        // Empty for 20 cycles, then one word every third cycle
        base4 = rdp_a;
        for (int i = 0; i < 10; i++) mem_a[8'(base4 + 32'(i))] = 16'd40 + 16'(i);
        fill_a = base4;
        pulse_a_start();
        repeat (20) @(negedge clk);
        chk("t4_wc_empty", a_wc, 0);
        chk("t4_busy_empty", a_busy, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1 fill_a = fill_a + 1;
            repeat (2) @(posedge clk);
        end
        wait_a_wc("t4_wc", 10, 50);
        stop_a("t4_idle");
        chk("t4_ec", a_ec, 0);
        chk("t4_rden_while_empty", 32'(viol_a), 0);

        // Reset in the middle of a run
        seq_q(16'd0, 100, q);
        load_a(q);
        pulse_a_start();
        wait_a_wc("t5_wc50", 50, 200);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_rden", a_rd_en, 0);
        chk("t5_rst_busy", a_busy, 0);
        chk("t5_rst_wc", a_wc, 0);
        chk("t5_rst_ec", a_ec, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seq_q(16'd100, 10, q);
        load_a(q);
        pulse_a_start();
        wait_a_wc("t5_fresh_wc", 10, 50);
        stop_a("t5_idle");
        chk("t5_fresh_ec", a_ec, 0);
        chk("t5_fresh_last", a_last, 16'd109);

        // RD_LATENCY=2: stop while two reads are in flight
        for (int i = 0; i < 8; i++) mem_b[8'(rdp_b + 32'(i))] = 16'(i);
        fill_b = rdp_b + 32'd8;
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        @(negedge clk);
        chk("t6_rden_run", b_rd_en, 1);
        @(posedge clk); #1;
        @(posedge clk); #1 b_stop = 1'b1;
        @(negedge clk);
        chk("t6_rden_last", b_rd_en, 1);
        @(posedge clk); #1 b_stop = 1'b0;
        @(negedge clk);
        chk("t6_rden_drain", b_rd_en, 0);
        chk("t6_busy_p1", b_busy, 1);
        chk("t6_wc_p1", b_wc, 1);
        @(negedge clk);
        chk("t6_busy_p2", b_busy, 1);
        chk("t6_wc_p2", b_wc, 2);
        @(negedge clk);
        chk("t6_busy_p3", b_busy, 0);
        chk("t6_wc", b_wc, 3);
        chk("t6_last", b_last, 16'd2);
        chk("t6_ec", b_ec, 0);
        repeat (2) @(negedge clk);
        chk("t6_idle_rden", b_rd_en, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
